// File: rtl/router_pkg.sv
// Shared router port-protocol definitions: default address/payload
// widths and the serial-port state encoding used by portout and portin.
package router_pkg;

    localparam int ADDR_W    = 4;
    localparam int PAYLOAD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PAD,
        DATA,
        GAP
    } port_state_t;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/router_piso.sv
// Loadable LSB-first parallel-in/serial-out shift register.
// Ports: clock, reset_n (async low), clear, load/din, shift, dout = q[0].
module router_piso #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q >> 1;
        end
    end

    assign dout = q[0];

endmodule

// File: rtl/portout.sv
// Serial transmitter for one router port: frames addr + payload onto
// frame_n/valid_n/dout. Ports: clock, reset_n, clear, start/addr/payload
// in; ready, done, frame_n, valid_n, dout out (all registered).
module portout #(
    parameter int ADDR_W     = router_pkg::ADDR_W,
    parameter int PAYLOAD_W  = router_pkg::PAYLOAD_W,
    parameter int PAD_CYCLES = 1,
    parameter int IFG_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 ready,
    output logic                 done,
    output logic                 frame_n,
    output logic                 valid_n,
    output logic                 dout
);

    import router_pkg::*;

    localparam int CNT_MAX = max4(ADDR_W, PAD_CYCLES, PAYLOAD_W, IFG_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0] PAD_LAST  = CW'(PAD_CYCLES - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(PAYLOAD_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(IFG_CYCLES - 1);

    port_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic accept;
    logic abit, pbit;

    logic frame_d, valid_d, dout_d, done_d;

    assign accept = start & ready & (state == IDLE) & ~clear;

    router_piso #(.W(ADDR_W)) u_addr_sr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .load    (accept),
        .shift   (state == ADDR),
        .din     (addr),
        .dout    (abit)
    );

    router_piso #(.W(PAYLOAD_W)) u_data_sr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .load    (accept),
        .shift   (state == DATA),
        .din     (payload),
        .dout    (pbit)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept) state_n = ADDR;
            ADDR: if (cnt == ADDR_LAST)
                      state_n = (PAD_CYCLES == 0) ? DATA : PAD;
            PAD:  if (cnt == PAD_LAST) state_n = DATA;
            DATA: if (cnt == DATA_LAST) state_n = GAP;
            GAP:  if (cnt == GAP_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (clear) state_n = IDLE;
    end

    // Counter restarts on every state change and never runs in IDLE.
    always_comb begin
        cnt_n = cnt + 1'b1;
        if (clear || state_n != state || state_n == IDLE) cnt_n = '0;
    end

    // Line values for the cycle after this edge, decoded from the
    // current state so the lines trail the FSM by one register stage.
    always_comb begin
        frame_d = 1'b1;
        valid_d = 1'b1;
        dout_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state)
            ADDR: begin
                frame_d = 1'b0;
                dout_d  = abit;
            end
            PAD: begin
                frame_d = 1'b0;
            end
            DATA: begin
                valid_d = 1'b0;
                dout_d  = pbit;
                frame_d = (cnt == DATA_LAST);
                done_d  = (cnt == DATA_LAST);
            end
            default: ;
        endcase
        if (clear) begin
            frame_d = 1'b1;
            valid_d = 1'b1;
            dout_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            frame_n <= 1'b1;
            valid_n <= 1'b1;
            dout    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ready   <= (state_n == IDLE);
            done    <= done_d;
            frame_n <= frame_d;
            valid_n <= valid_d;
            dout    <= dout_d;
        end
    end

endmodule

// File: tb/tb_portout.sv
// Directed self-checking bench for portout: two instances, one with
// default pad/gap and one with PAD_CYCLES=0, IFG_CYCLES=3.
module tb_portout;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        start1, start2;
    logic [3:0]  addr;
    logic [31:0] payload;

    logic ready1, done1, frame_n1, valid_n1, dout1;
    logic ready2, done2, frame_n2, valid_n2, dout2;
    logic [4:0] o1, o2;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [4:0] IDLE_V = 5'b10110;

    always #5 clock = ~clock;

    assign o1 = {ready1, done1, frame_n1, valid_n1, dout1};
    assign o2 = {ready2, done2, frame_n2, valid_n2, dout2};

    portout #(
        .ADDR_W(4), .PAYLOAD_W(32), .PAD_CYCLES(1), .IFG_CYCLES(1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .start(start1), .addr(addr), .payload(payload),
        .ready(ready1), .done(done1), .frame_n(frame_n1),
        .valid_n(valid_n1), .dout(dout1)
    );

    portout #(
        .ADDR_W(4), .PAYLOAD_W(32), .PAD_CYCLES(0), .IFG_CYCLES(3)
    ) dut2 (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .start(start2), .addr(addr), .payload(payload),
        .ready(ready2), .done(done2), .frame_n(frame_n2),
        .valid_n(valid_n2), .dout(dout2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int k,
                       input logic [4:0] obs, input logic [4:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle %0d {rdy,done,frame_n,valid_n,dout} observed=%b expected=%b",
                   tag, k, obs, exp);
        end
    endtask

    // Expected {ready,done,frame_n,valid_n,dout} in cycle k after accept.
    function automatic logic [4:0] model(input logic [3:0] a,
                                         input logic [31:0] p,
                                         input int pad, input int ifg,
                                         input int k);
        int len;
        int j;
        logic [4:0] e;
        len = 4 + pad + 32;
        e = 5'b00110;
        if (k >= 1 && k <= 4) begin
            e = {4'b0001, a[k-1]};
        end else if (k >= 5 && k <= 4 + pad) begin
            e = 5'b00010;
        end else if (k > 4 + pad && k <= len) begin
            j = k - 5 - pad;
            e = {1'b0, j == 31, j == 31, 1'b0, p[j]};
        end
        if (k == len + ifg) e[4] = 1'b1;
        return e;
    endfunction

    task automatic drive(input bit sel, input logic v);
        if (sel) start2 = v;
        else     start1 = v;
    endtask

    // Precondition: start for sel is 1 with addr=a/payload=p, ready=1.
    task automatic frame(input bit sel, input logic [3:0] a,
                         input logic [31:0] p, input int pad,
                         input int ifg, input logic [3:0] na,
                         input logic [31:0] np, input bit hold,
                         input int pk, input string tag);
        int last;
        last = 4 + pad + 32 + ifg;
        tick();
        addr    = na;
        payload = np;
        for (int k = 0; k <= last; k++) begin
            drive(sel, hold || (k == pk));
            chk(tag, k, sel ? o2 : o1, model(a, p, pad, ifg, k));
            if (k < last) tick();
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, i, o1, IDLE_V);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        addr    = '0;
        payload = '0;
        #12;
        chk("reset", 0, o1, IDLE_V);
        chk("reset2", 0, o2, IDLE_V);
        #5;
        reset_n = 1'b1;

        idle_check(10, "idle");

        addr = 4'hA; payload = 32'hDEADBEEF; start1 = 1'b1;
        frame(0, 4'hA, 32'hDEADBEEF, 1, 1, 4'h5, 32'h0, 0, -1, "single");

        addr = 4'h3; payload = 32'h1; start1 = 1'b1;
        frame(0, 4'h3, 32'h1, 1, 1, 4'hC, 32'hFFFFFFFF, 1, -1, "b2b_1");
        frame(0, 4'hC, 32'hFFFFFFFF, 1, 1, 4'h0, 32'h0, 0, -1, "b2b_2");
        idle_check(2, "b2b_end");

        addr = 4'h5; payload = 32'h8000_0001; start1 = 1'b1;
        frame(0, 4'h5, 32'h8000_0001, 1, 1, 4'h0, 32'h0, 0, 20,
              "pulse_data");
        idle_check(3, "pulse_data_end");

        addr = 4'h6; payload = 32'h0F0F_1234; start1 = 1'b1;
        frame(0, 4'h6, 32'h0F0F_1234, 1, 1, 4'h0, 32'h0, 0, 37,
              "pulse_gap");
        idle_check(3, "pulse_gap_end");

        addr = 4'h6; payload = 32'h1234_5678; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("pre_clear", 20, o1, model(4'h6, 32'h1234_5678, 1, 1, 20));
        clear = 1'b1;
        start1 = 1'b1;
        tick();
        chk("clear", 21, o1, IDLE_V);
        tick();
        chk("clear_prio", 22, o1, IDLE_V);
        clear = 1'b0;
        addr = 4'h9; payload = 32'hA5A5_0F0F;
        frame(0, 4'h9, 32'hA5A5_0F0F, 1, 1, 4'h0, 32'h0, 0, -1,
              "post_clear");

        addr = 4'hF; payload = 32'h0000_8001; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("pre_reset", 3, o1, model(4'hF, 32'h0000_8001, 1, 1, 3));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 3, o1, IDLE_V);
        #3;
        reset_n = 1'b1;
        tick();
        chk("after_reset", 0, o1, IDLE_V);

        addr = 4'hB; payload = 32'hCAFE_0001; start2 = 1'b1;
        frame(1, 4'hB, 32'hCAFE_0001, 0, 3, 4'h0, 32'h0, 0, -1,
              "pad0_ifg3");
        tick();
        chk("pad0_idle", 0, o2, IDLE_V);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
